background_redraw_ctrl: RTL

- Sequences a full-screen background repaint whenever the game state changes.
- Walks every pixel coordinate, drives it into the background pixel lookup, and waits out the lookup ROM latency.
- Forwards the aligned coordinate and colour to the VGA adapter write port.
- Sits between the game-state FSM, the background lookup and the VGA adapter. Sprite drawers read `busy` and stay off the VGA port while it is high.

---
 rtl/background_redraw_ctrl_pkg.sv | 46 ++++
 rtl/background_redraw_ctrl_pixel_scan_counter.sv | 42 ++++
 rtl/background_redraw_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/background_redraw_ctrl_pkg.sv
// Graphics definitions shared by the redraw controller, the background lookup and the game FSM.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package background_redraw_ctrl_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int X_W      = 9;
   localparam int Y_W      = 8;
   localparam int COLOR_W  = 3;
   localparam int STATE_W  = 4;

   // Game states; the background lookup selects its artwork from these.
   typedef enum logic [STATE_W-1:0] {
      DRAW_INITIAL   = 4'd0,
      DRAW_TITLE     = 4'd1,
      WAIT_START     = 4'd2,
      DRAW_LEVEL     = 4'd3,
      PLAYING        = 4'd4,
      PAUSED         = 4'd5,
      PLAYER_HIT     = 4'd6,
      LEVEL_CLEAR    = 4'd7,
      DRAW_GAME_OVER = 4'd8,
      WAIT_RESTART   = 4'd9,
      DRAW_WIN       = 4'd10,
      FINISHED_GAME  = 4'd11
   } game_state_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } redraw_state_e;

   // One entry of the coordinate delay line that tracks the lookup ROM.
   typedef struct packed {
      logic           vld;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } pix_tag_t;

   // Not a legal game state, so the first cycle after reset always requests a redraw.
   localparam logic [STATE_W-1:0] PREV_STATE_RST = 4'hF;

endpackage

// File: rtl/background_redraw_ctrl_pixel_scan_counter.sv
// Raster X/Y counter: x runs 0..H_RES-1, then y advances; wraps to (0,0) after the last pixel.
// Latency: registered coordinates, last flag combinational from the current coordinate.
// Backpressure: advances only while en is high; clr has priority and returns to (0,0).
module pixel_scan_counter
   import background_redraw_ctrl_pkg::*;
#(
   parameter int H_RES = SCREEN_W,
   parameter int V_RES = SCREEN_H
)(
   input  logic           clock,
   input  logic           reset,
   input  logic           en,
   input  logic           clr,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

   // Step the raster position one pixel per enabled cycle.
   always_ff @(posedge clock) begin
      if (reset || clr) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + Y_W'(1);
         end else begin
            x <= x + X_W'(1);
         end
      end
   end

   // Flag the final pixel of the frame.
   always_comb begin
      last = (x == X_LAST) && (y == Y_LAST);
   end

endmodule

// File: rtl/background_redraw_ctrl.sv
// Full-screen background repaint on game-state change or request; optional SKIP_BLACK_EN suppresses black plots.
// Latency: coordinate issued at cycle t is plotted at t+ROM_LATENCY+1; frame = H_RES*V_RES+ROM_LATENCY+2 cycles.
// Backpressure: none; triggers arriving mid-frame collapse into one pending redraw run after done.
module background_redraw_ctrl
   import background_redraw_ctrl_pkg::*;
#(
   parameter int H_RES       = SCREEN_W,
   parameter int V_RES       = SCREEN_H,
   parameter int ROM_LATENCY = 1          // lookup ROM latency, 1..3
)(
   input  logic               clock,
   input  logic               reset,
   input  logic [STATE_W-1:0] gameState,
   input  logic               redraw_req,
   input  logic [COLOR_W-1:0] bg_color,
   output logic [X_W-1:0]     bg_x,
   output logic [Y_W-1:0]     bg_y,
   output logic [X_W-1:0]     vga_x,
   output logic [Y_W-1:0]     vga_y,
   output logic [COLOR_W-1:0] vga_colour,
   output logic               vga_plot,
   output logic               busy,
   output logic               done
);

   redraw_state_e      state;
   logic               pending;
   logic [STATE_W-1:0] prev_state;
   logic               trigger;
   logic               scan_en;
   logic               scan_clr;
   logic               scan_last;
   logic               pipe_any_vld;
   logic               plot_next;
   pix_tag_t           issue_tag;
   pix_tag_t           tail;
   pix_tag_t           pipe [ROM_LATENCY];

   pixel_scan_counter #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_scan (
      .clock (clock),
      .reset (reset),
      .en    (scan_en),
      .clr   (scan_clr),
      .x     (bg_x),
      .y     (bg_y),
      .last  (scan_last)
   );

   // Redraw request decode and counter control derived from the current state.
   always_comb begin
      trigger   = (gameState != prev_state) || redraw_req;
      scan_en   = (state == ST_SCAN);
      scan_clr  = ((state == ST_IDLE) && trigger) ||
                  ((state == ST_DONE) && (pending || trigger));
      issue_tag = '{vld: scan_en, x: bg_x, y: bg_y};
      tail      = pipe[ROM_LATENCY-1];
   end

   // Any coordinate still waiting for its colour keeps the frame in flush.
   always_comb begin
      pipe_any_vld = 1'b0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
         pipe_any_vld = pipe_any_vld | pipe[i].vld;
      end
   end

   // Frame sequencer: idle, scan every pixel, drain the lookup, pulse done.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         pending    <= 1'b0;
         prev_state <= PREV_STATE_RST;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         prev_state <= gameState;
         done       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  state <= ST_SCAN;
                  busy  <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (trigger) pending <= 1'b1;
               if (scan_last) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (trigger) pending <= 1'b1;
               // Empty delay line means the output register holds the final plot now.
               if (!pipe_any_vld) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            ST_DONE: begin
               // A trigger landing in this cycle counts as pending too.
               if (pending || trigger) begin
                  pending <= 1'b0;
                  state   <= ST_SCAN;
                  busy    <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Delay line aligning each issued coordinate with its ROM colour.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < ROM_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= issue_tag;
         for (int i = 1; i < ROM_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   // Plot enable for the aligned pixel.
   always_comb begin
`ifdef SKIP_BLACK_EN
      plot_next = tail.vld && (bg_color != '0);
`else
      plot_next = tail.vld;
`endif
   end

   // Registered VGA write port.
   always_ff @(posedge clock) begin
      if (reset) begin
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         vga_x      <= tail.x;
         vga_y      <= tail.y;
         vga_colour <= bg_color;
         vga_plot   <= plot_next;
      end
   end

endmodule
